// File: rtl/mbuf_pkg.sv
// Shared types and AXI encodings for the multi-buffer AXI4 write slave.
package mbuf_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    RESP
  } wr_state_t;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Only FIXED and INCR map onto sequential fill; WRAP and the reserved code are errors.
  function automatic logic burst_is_err(input logic [1:0] burst);
    return !((burst == BURST_FIXED) || (burst == BURST_INCR));
  endfunction

endpackage

// File: rtl/mbuf_bank.sv
// One burst buffer: beat storage with per-byte-lane write enables, stored beat count and full flag.
module mbuf_bank #(
  parameter int DW_g    = 64,
  parameter int DEPTH_g = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic [DW_g/8-1:0]          we_i,
  input  logic [$clog2(DEPTH_g)-1:0] waddr_i,
  input  logic [DW_g-1:0]            wdata_i,
  input  logic [$clog2(DEPTH_g)-1:0] raddr_i,
  output logic [DW_g-1:0]            rdata_o,
  input  logic                       set_i,
  input  logic [$clog2(DEPTH_g):0]   count_i,
  input  logic                       clr_i,
  output logic                       full_o,
  output logic [$clog2(DEPTH_g):0]   count_o
);

  logic [DW_g-1:0] mem [DEPTH_g];

  // NOTE: storage is deliberately not reset; the full flag and count gate every read.
  always_ff @(posedge clk_i) begin
    for (int l = 0; l < DW_g / 8; l++) begin
      if (we_i[l]) mem[waddr_i][l*8 +: 8] <= wdata_i[l*8 +: 8];
    end
  end

  assign rdata_o = mem[raddr_i];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      full_o  <= 1'b0;
      count_o <= '0;
    end else if (set_i) begin
      full_o  <= 1'b1;
      count_o <= count_i;
    end else if (clr_i) begin
      full_o  <= 1'b0;
    end
  end

endmodule

// File: rtl/multi_buffer_axi_wr_slv.sv
// AXI4 write slave filling NUM_BUF_g ring-ordered buffers, drained in fill order onto a stream.
// Optional macro MBUF_STRB_EN: honour wstrb per byte lane instead of writing full words.
module multi_buffer_axi_wr_slv
  import mbuf_pkg::*;
#(
  parameter int AXI_DW_g    = 64,
  parameter int AXI_AW_g    = 32,
  parameter int NUM_BUF_g   = 4,
  parameter int BUF_DEPTH_g = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  output logic                  s_axi_awready_o,
  input  logic                  s_axi_awvalid_i,
  input  logic [AXI_AW_g-1:0]   s_axi_awaddr_i,
  input  logic [7:0]            s_axi_awlen_i,
  input  logic [2:0]            s_axi_awsize_i,
  input  logic [1:0]            s_axi_awburst_i,
  output logic                  s_axi_wready_o,
  input  logic                  s_axi_wvalid_i,
  input  logic [AXI_DW_g-1:0]   s_axi_wdata_i,
  input  logic [AXI_DW_g/8-1:0] s_axi_wstrb_i,
  input  logic                  s_axi_wlast_i,
  input  logic                  s_axi_bready_i,
  output logic                  s_axi_bvalid_o,
  output logic [1:0]            s_axi_bresp_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [AXI_DW_g-1:0]   m_data_o,
  output logic                  m_last_o,
  output logic [NUM_BUF_g-1:0]  buf_full_o
);

  localparam int SW  = AXI_DW_g / 8;
  localparam int PW  = $clog2(NUM_BUF_g);
  localparam int DAW = $clog2(BUF_DEPTH_g);
  localparam logic [DAW:0] DEPTH_C = (DAW + 1)'(BUF_DEPTH_g);

  wr_state_t      state;
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [DAW:0]   beat_cnt;
  logic [DAW-1:0] rd_cnt;
  logic [7:0]     len_left;
  logic           err;

  logic [AXI_DW_g-1:0] bank_rdata [NUM_BUF_g];
  logic [DAW:0]        bank_count [NUM_BUF_g];
  logic [DAW:0]        rd_count;
  logic [SW-1:0]       lane_en;

  logic aw_hs, w_hs, b_hs, drain_done;
  logic beat_sat, len_err, beat_err, buf_free;
  logic [DAW:0] fill_count;

`ifdef MBUF_STRB_EN
  assign lane_en = s_axi_wstrb_i;
  logic unused_ok;
  assign unused_ok = ^{s_axi_awaddr_i, s_axi_awsize_i};
`else
  assign lane_en = '1;
  logic unused_ok;
  assign unused_ok = ^{s_axi_awaddr_i, s_axi_awsize_i, s_axi_wstrb_i};
`endif

  assign aw_hs      = s_axi_awvalid_i && s_axi_awready_o;
  assign w_hs       = s_axi_wvalid_i && s_axi_wready_o;
  assign b_hs       = s_axi_bvalid_o && s_axi_bready_i;
  assign drain_done = m_valid_o && m_ready_i && m_last_o;

  // Beats past the buffer depth are swallowed; len_left flags early or late wlast.
  assign beat_sat   = (beat_cnt == DEPTH_C);
  assign len_err    = s_axi_wlast_i ? (len_left != 8'd0) : (len_left == 8'd0);
  assign beat_err   = err || beat_sat || len_err;
  assign fill_count = beat_sat ? DEPTH_C : beat_cnt + 1'b1;

  // Lookahead so awready rises in the cycle the drained buffer reads empty, never earlier.
  assign buf_free   = !buf_full_o[wr_ptr] || (drain_done && (rd_ptr == wr_ptr));

  for (genvar b = 0; b < NUM_BUF_g; b++) begin : g_bank
    mbuf_bank #(
      .DW_g    (AXI_DW_g),
      .DEPTH_g (BUF_DEPTH_g)
    ) u_bank (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .we_i    ((w_hs && !beat_sat && (wr_ptr == PW'(b))) ? lane_en : '0),
      .waddr_i (beat_cnt[DAW-1:0]),
      .wdata_i (s_axi_wdata_i),
      .raddr_i (rd_cnt),
      .rdata_o (bank_rdata[b]),
      .set_i   (w_hs && s_axi_wlast_i && (wr_ptr == PW'(b))),
      .count_i (fill_count),
      .clr_i   (drain_done && (rd_ptr == PW'(b))),
      .full_o  (buf_full_o[b]),
      .count_o (bank_count[b])
    );
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state           <= IDLE;
      s_axi_awready_o <= 1'b0;
      s_axi_wready_o  <= 1'b0;
      s_axi_bvalid_o  <= 1'b0;
      s_axi_bresp_o   <= RESP_OKAY;
      wr_ptr          <= '0;
      beat_cnt        <= '0;
      len_left        <= '0;
      err             <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (aw_hs) begin
            state           <= DATA;
            s_axi_awready_o <= 1'b0;
            s_axi_wready_o  <= 1'b1;
            beat_cnt        <= '0;
            len_left        <= s_axi_awlen_i;
            err             <= burst_is_err(s_axi_awburst_i);
          end else begin
            s_axi_awready_o <= buf_free;
          end
        end
        DATA: begin
          if (w_hs) begin
            if (!beat_sat) beat_cnt <= beat_cnt + 1'b1;
            if (s_axi_wlast_i) begin
              state          <= RESP;
              s_axi_wready_o <= 1'b0;
              s_axi_bvalid_o <= 1'b1;
              s_axi_bresp_o  <= beat_err ? RESP_SLVERR : RESP_OKAY;
              wr_ptr         <= wr_ptr + 1'b1;
            end else begin
              err <= beat_err;
              if (len_left != 8'd0) len_left <= len_left - 1'b1;
            end
          end
        end
        RESP: begin
          if (b_hs) begin
            state           <= IDLE;
            s_axi_bvalid_o  <= 1'b0;
            s_axi_awready_o <= buf_free;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rd_count  = bank_count[rd_ptr];
  assign m_valid_o = buf_full_o[rd_ptr];
  assign m_last_o  = m_valid_o && ({1'b0, rd_cnt} == rd_count - 1'b1);
  assign m_data_o  = m_valid_o ? bank_rdata[rd_ptr] : '0;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_ptr <= '0;
      rd_cnt <= '0;
    end else if (m_valid_o && m_ready_i) begin
      if (m_last_o) begin
        rd_cnt <= '0;
        rd_ptr <= rd_ptr + 1'b1;
      end else begin
        rd_cnt <= rd_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_multi_buffer_axi_wr_slv.sv
// Directed bench for multi_buffer_axi_wr_slv (4 buffers x 16 beats x 64 bits); honours MBUF_STRB_EN.
module tb_multi_buffer_axi_wr_slv;
  import mbuf_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        awready, awvalid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        wready, wvalid, wlast;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        bready, bvalid;
  logic [1:0]  bresp;
  logic        m_valid, m_ready, m_last;
  logic [63:0] m_data;
  logic [3:0]  buf_full;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multi_buffer_axi_wr_slv #(
    .AXI_DW_g    (64),
    .AXI_AW_g    (32),
    .NUM_BUF_g   (4),
    .BUF_DEPTH_g (16)
  ) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .s_axi_awready_o (awready),
    .s_axi_awvalid_i (awvalid),
    .s_axi_awaddr_i  (awaddr),
    .s_axi_awlen_i   (awlen),
    .s_axi_awsize_i  (awsize),
    .s_axi_awburst_i (awburst),
    .s_axi_wready_o  (wready),
    .s_axi_wvalid_i  (wvalid),
    .s_axi_wdata_i   (wdata),
    .s_axi_wstrb_i   (wstrb),
    .s_axi_wlast_i   (wlast),
    .s_axi_bready_i  (bready),
    .s_axi_bvalid_o  (bvalid),
    .s_axi_bresp_o   (bresp),
    .m_valid_o       (m_valid),
    .m_ready_i       (m_ready),
    .m_data_o        (m_data),
    .m_last_o        (m_last),
    .buf_full_o      (buf_full)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // NOTE: inputs change 1ns after the active edge, so outputs read here are stable for the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
  endtask

  task automatic send_aw(input logic [7:0] len, input logic [1:0] burst);
    int t = 0;
    awvalid = 1'b1;
    awlen   = len;
    awburst = burst;
    awaddr  = $urandom;
    awsize  = 3'd3;
    while (!awready && t < 50) begin
      tick();
      t++;
    end
    check("aw_accept", awready, 1'b1);
    tick();
    awvalid = 1'b0;
  endtask

  task automatic send_w(input int n, input logic [63:0] base, input logic [7:0] strb);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      wvalid = 1'b1;
      wdata  = base + 64'(i);
      wstrb  = strb;
      wlast  = (i == n - 1);
      while (!wready && t < 50) begin
        tick();
        t++;
      end
      if (t == 50) check("w_timeout", wready, 1'b1);
      tick();
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
  endtask

  task automatic get_b(input logic [1:0] exp_resp);
    int t = 0;
    bready = 1'b1;
    while (!bvalid && t < 50) begin
      tick();
      t++;
    end
    check("b_valid", bvalid, 1'b1);
    check("b_resp", bresp, exp_resp);
    tick();
    bready = 1'b0;
  endtask

  task automatic drain(input int n, input logic [63:0] base);
    m_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      int t = 0;
      while (!m_valid && t < 50) begin
        tick();
        t++;
      end
      check("m_data", m_data, base + 64'(i));
      check("m_last", m_last, (i == n - 1));
      tick();
    end
    m_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] strb_exp;
    awvalid = 1'b0; awaddr = '0; awlen = '0; awsize = '0; awburst = BURST_INCR;
    wvalid  = 1'b0; wdata = '0; wstrb = '1; wlast = 1'b0;
    bready  = 1'b0; m_ready = 1'b0;

    // Reset state
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_awready", awready, 1'b0);
    check("rst_wready", wready, 1'b0);
    check("rst_bvalid", bvalid, 1'b0);
    check("rst_bresp", bresp, RESP_OKAY);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_last", m_last, 1'b0);
    check("rst_m_data", m_data, 64'h0);
    check("rst_buf_full", buf_full, 4'h0);
    rst_n = 1'b1;
    tick();
    tick();
    check("idle_awready", awready, 1'b1);

    // Single INCR burst of 4 beats
    send_aw(8'd3, BURST_INCR);
    send_w(4, 64'h10, 8'hFF);
    get_b(RESP_OKAY);
    check("single_full", buf_full, 4'h1);
    drain(4, 64'h10);
    check("single_empty", buf_full, 4'h0);

    // Four full bursts with the stream stalled, then a fifth blocked on buffer 0
    do_reset();
    for (int k = 0; k < 4; k++) begin
      send_aw(8'd15, BURST_INCR);
      send_w(16, 64'h1000 * 64'(k + 1), 8'hFF);
      get_b(RESP_OKAY);
    end
    check("all_full", buf_full, 4'hF);
    awvalid = 1'b1;
    awlen   = 8'd15;
    awburst = BURST_INCR;
    repeat (3) tick();
    check("aw_blocked", awready, 1'b0);
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("buf0_data", m_data, 64'h1000 + 64'(i));
      check("aw_still_blocked", awready, 1'b0);
      tick();
    end
    m_ready = 1'b0;
    check("buf0_freed", buf_full, 4'hE);
    check("aw_reopens", awready, 1'b1);
    tick();
    awvalid = 1'b0;
    check("fifth_in_data", wready, 1'b1);
    send_w(16, 64'h5000, 8'hFF);
    get_b(RESP_OKAY);
    check("refull", buf_full, 4'hF);
    drain(16, 64'h2000);
    drain(16, 64'h3000);
    drain(16, 64'h4000);
    drain(16, 64'h5000);
    check("ring_empty", buf_full, 4'h0);

    // Overlong burst: 20 beats accepted, 16 stored
    send_aw(8'd19, BURST_INCR);
    send_w(20, 64'h6000, 8'hFF);
    get_b(RESP_SLVERR);
    drain(16, 64'h6000);

    // WRAP burst is stored but flagged
    send_aw(8'd1, BURST_WRAP);
    send_w(2, 64'h7000, 8'hFF);
    get_b(RESP_SLVERR);
    drain(2, 64'h7000);

    // Early wlast on beat 3 of 8
    send_aw(8'd7, BURST_INCR);
    send_w(3, 64'h8000, 8'hFF);
    get_b(RESP_SLVERR);
    drain(3, 64'h8000);
    check("err_ring_empty", buf_full, 4'h0);

    // Partial-strobe rewrite of buffer 0 slot 0
    do_reset();
    send_aw(8'd0, BURST_INCR);
    send_w(1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    get_b(RESP_OKAY);
    for (int k = 1; k < 4; k++) begin
      send_aw(8'd0, BURST_FIXED);
      send_w(1, 64'(k), 8'hFF);
      get_b(RESP_OKAY);
    end
    drain(1, 64'hFFFF_FFFF_FFFF_FFFF);
    drain(1, 64'h1);
    drain(1, 64'h2);
    drain(1, 64'h3);
    send_aw(8'd0, BURST_INCR);
    send_w(1, 64'h0, 8'h0F);
    get_b(RESP_OKAY);
`ifdef MBUF_STRB_EN
    strb_exp = 64'hFFFF_FFFF_0000_0000;
`else
    strb_exp = 64'h0;
`endif
    drain(1, strb_exp);

    // Reset asserted during beat 2 of an 8-beat burst
    send_aw(8'd7, BURST_INCR);
    wvalid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wdata = 64'h9000 + 64'(i);
      tick();
    end
    wdata = 64'h9002;
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_bvalid", bvalid, 1'b0);
    check("mid_rst_wready", wready, 1'b0);
    check("mid_rst_full", buf_full, 4'h0);
    wvalid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("post_rst_m_valid", m_valid, 1'b0);
    check("post_rst_awready", awready, 1'b1);
    check("post_rst_bvalid", bvalid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
